priority_encoder_hs: RTL and testbench
======================================

PRIORITY_ENCODER_HS -- requirements
Module: priority_encoder_hs

Interface
REQ-001 The block SHALL have a parameter N, default 10, setting the number of request inputs (N >= 2).
REQ-002 The block SHALL have a parameter W, default $clog2(N), setting the width of the output code.
REQ-003 The block SHALL have a parameter MSB_FIRST, default 0: 0 means the lowest set index wins, 1 means the highest set index wins.
REQ-004 The block SHALL have a parameter SYNC_STAGES, default 2, setting the synchroniser depth (>= 2).
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have the port in_req, input, N bits: asynchronous request lines (switches/keys), active-high.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: a code is held for the consumer.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the code.
REQ-010 The block SHALL have the port out_code, output, W bits: the encoded winning index.
REQ-011 The block SHALL have the port out_multi, output, 1 bit: more than one bit was set at capture.
REQ-012 The block SHALL have the port err_drop, output, 1 bit: a one-cycle pulse when a new request is ignored.

Function
REQ-013 Each in_req bit SHALL pass through a SYNC_STAGES flop synchroniser; the result is s_req.
REQ-014 A registered copy s_prev of s_req SHALL be kept; new bits are defined as rise = s_req & ~s_prev.
REQ-015 The FSM SHALL have three states: IDLE, HOLD and WAIT_REL.
REQ-016 In IDLE with s_req != 0, the block SHALL capture the priority index into out_code and set out_multi = (popcount(s_req) > 1).
  - On that capture the FSM SHALL go to HOLD, with out_valid = 1 from the next cycle.
REQ-017 The latency from an in_req edge to out_valid = 1 SHALL be SYNC_STAGES+1 cycles.
REQ-018 In HOLD, out_code, out_multi and out_valid SHALL stay stable until out_valid && out_ready.
REQ-019 On the handshake, out_valid SHALL clear on the next cycle.
  - The FSM SHALL go to IDLE if s_req == 0 in that cycle, else to WAIT_REL.
REQ-020 WAIT_REL SHALL go to IDLE in the first cycle with s_req == 0; no capture SHALL occur in WAIT_REL.
REQ-021 In HOLD or WAIT_REL, rise != 0 SHALL pulse err_drop high for exactly one cycle; the state SHALL be unchanged.
REQ-022 out_ready while in IDLE or WAIT_REL SHALL be ignored.
REQ-023 A request that is released before the handshake SHALL still be held and delivered; the FSM then goes HOLD -> IDLE.
REQ-024 The priority logic SHALL be a parametrised loop, with no per-N case table.
REQ-025 An index >= 2^W cannot occur; W SHALL be checked >= $clog2(N) by an elaboration assertion.

Reset
REQ-026 While rst_n = 0, the state SHALL be IDLE and all of the following SHALL be 0: synchroniser flops, s_prev, out_valid, out_code, out_multi, err_drop.
REQ-027 Reset asserted mid-HOLD SHALL drop the pending code with no err_drop.
REQ-028 After reset release, a still-pressed key SHALL be captured as a fresh request after SYNC_STAGES+1 cycles.

Structure
REQ-029 Package enc_pkg SHALL hold the state enum (enc_state_t: IDLE, HOLD, WAIT_REL) and a popcount>1 helper function.
REQ-030 Sub-module sync_bus (N-wide, SYNC_STAGES deep, async reset) SHALL implement the synchroniser.
REQ-031 The FSM, the capture registers and the err_drop logic SHALL stay in priority_encoder_hs.

Verification (N=10, SYNC_STAGES=2)
REQ-032 Single press: in_req=0x020, out_ready=1 -> out_valid at cycle +3, out_code=5, out_multi=0.
  - Then WAIT_REL until in_req=0.
REQ-033 Priority order:
  - in_req=0x204, MSB_FIRST=0 -> out_code=2, out_multi=1.
  - Same stimulus with MSB_FIRST=1 -> out_code=9.
REQ-034 Backpressure: in_req=0x008, out_ready=0 for 20 cycles.
  - Then set in_req=0x108 -> code stays 3, one err_drop pulse.
  - Then out_ready=1 -> one transfer.
REQ-035 Release before accept: in_req=0x001 for 4 cycles, then 0; out_ready rises at cycle 10.
  - Required response: code 0 delivered once, FSM returns to IDLE.
REQ-036 Reset in HOLD: out_valid=1, code=7, rst_n pulsed low.
  - Required response: all outputs 0 asynchronously.
  - With in_req=0x080 held, code 7 reappears 3 cycles after release.
REQ-037 Idle ready: out_ready=1 and in_req=0 for 50 cycles -> out_valid and err_drop stay 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and helpers for the handshaked priority encoder.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } enc_state_t;

  // Widest request bus the multi-hot helper accepts; callers zero-extend.
  localparam int ENC_MAX_N = 64;
  localparam logic [ENC_MAX_N-1:0] ENC_ONE = {{(ENC_MAX_N-1){1'b0}}, 1'b1};

  // popcount(v) > 1 is equivalent to v having a bit left after clearing its lowest set bit.
  function automatic logic more_than_one(input logic [ENC_MAX_N-1:0] v);
    return |(v & (v - ENC_ONE));
  endfunction

endpackage

// File: rtl/sync_bus.sv
// N-wide multi-flop synchroniser for asynchronous request lines.
module sync_bus #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/priority_encoder_hs.sv
// Priority encoder for asynchronous keys: synchronise, capture one winning index,
// hold it under a valid/ready handshake and wait for release before re-arming.
module priority_encoder_hs
  import enc_pkg::*;
#(
  parameter int N           = 10,
  parameter int W           = $clog2(N),
  parameter bit MSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_multi,
  output logic         err_drop
);

  if (N < 2) begin : g_n_min
    $error("priority_encoder_hs: N must be at least 2");
  end
  if (N > ENC_MAX_N) begin : g_n_max
    $error("priority_encoder_hs: N exceeds ENC_MAX_N");
  end
  if (W < $clog2(N)) begin : g_w_chk
    $error("priority_encoder_hs: W too narrow to encode N indices");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("priority_encoder_hs: SYNC_STAGES must be at least 2");
  end

  logic [N-1:0] s_req;
  logic [N-1:0] s_prev;
  logic [N-1:0] rise;
  enc_state_t   state;

  sync_bus #(
    .N          (N),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (in_req),
    .q    (s_req)
  );

  assign rise = s_req & ~s_prev;

  // Scan so the preferred end is visited last; the last set bit seen wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] idx;
    int           i;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      i = MSB_FIRST ? k : (N - 1 - k);
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_prev    <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_multi <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      s_prev   <= s_req;
      err_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|s_req) begin
            out_code  <= pick(s_req);
            out_multi <= more_than_one(ENC_MAX_N'(s_req));
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          err_drop <= |rise;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= (|s_req) ? WAIT_REL : IDLE;
          end
        end
        WAIT_REL: begin
          err_drop <= |rise;
          if (!(|s_req)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder_hs.sv
// Directed bench for priority_encoder_hs: LSB-first and MSB-first instances share
// stimulus, and each handshake is scored against a per-instance expectation queue.
module tb_priority_encoder_hs;

  localparam int N = 10;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_req;
  logic         out_ready;

  logic         v0, m0, e0;
  logic [W-1:0] c0;
  logic         v1, m1, e1;
  logic [W-1:0] c1;

  int checks = 0;
  int errors = 0;
  int xfer0  = 0;
  int xfer1  = 0;
  int drop0  = 0;
  int drop1  = 0;

  logic [W:0] q0 [$];
  logic [W:0] q1 [$];

  priority_encoder_hs #(.N(N), .W(W), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .out_valid(v0),
    .out_ready(out_ready), .out_code(c0), .out_multi(m0), .err_drop(e0)
  );

  priority_encoder_hs #(.N(N), .W(W), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .out_valid(v1),
    .out_ready(out_ready), .out_code(c1), .out_multi(m1), .err_drop(e1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] mk(input logic [W-1:0] code, input logic multi);
    return {code, multi};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (e0) drop0++;
    if (e1) drop1++;
    if (rst_n && v0 && out_ready) begin
      xfer0++;
      checks++;
      assert (q0.size() != 0) else begin
        errors++;
        $error("FAIL u0_unexpected_xfer observed code=%0d expected none", c0);
      end
      if (q0.size() != 0) chk("u0_xfer", 32'({c0, m0}), 32'(q0.pop_front()));
    end
    if (rst_n && v1 && out_ready) begin
      xfer1++;
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("FAIL u1_unexpected_xfer observed code=%0d expected none", c1);
      end
      if (q1.size() != 0) chk("u1_xfer", 32'({c1, m1}), 32'(q1.pop_front()));
    end
  end

  initial begin
    int bx0, bx1, bd0, bd1;
    rst_n     = 1'b0;
    in_req    = '0;
    out_ready = 1'b0;
    ticks(2);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_code",  32'(c0), 32'd0);
    chk("rst_multi", 32'(m0), 32'd0);
    chk("rst_drop",  32'(e0), 32'd0);
    chk("rst_valid_u1", 32'(v1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single press, latency and release wait
    out_ready = 1'b1;
    q0.push_back(mk(4'd5, 1'b0));
    q1.push_back(mk(4'd5, 1'b0));
    bx0 = xfer0;
    in_req = 10'h020;
    ticks(2);
    chk("lat_before", 32'(v0), 32'd0);
    tick();
    chk("lat_at3", 32'(v0), 32'd1);
    chk("single_code", 32'(c0), 32'd5);
    chk("single_multi", 32'(m0), 32'd0);
    tick();
    chk("hs_clear", 32'(v0), 32'd0);
    chk("single_xfers", 32'(xfer0 - bx0), 32'd1);
    ticks(5);
    chk("wait_rel_no_recap", 32'(v0), 32'd0);
    chk("wait_rel_xfers", 32'(xfer0 - bx0), 32'd1);
    in_req = '0;
    ticks(4);

    // Priority order, both directions
    q0.push_back(mk(4'd2, 1'b1));
    q1.push_back(mk(4'd9, 1'b1));
    in_req = 10'h204;
    ticks(3);
    chk("prio_lsb_code", 32'(c0), 32'd2);
    chk("prio_lsb_multi", 32'(m0), 32'd1);
    chk("prio_msb_valid", 32'(v1), 32'd1);
    chk("prio_msb_code", 32'(c1), 32'd9);
    chk("prio_msb_multi", 32'(m1), 32'd1);
    ticks(4);
    in_req = '0;
    ticks(4);

    // Backpressure with a dropped new request
    out_ready = 1'b0;
    q0.push_back(mk(4'd3, 1'b0));
    q1.push_back(mk(4'd3, 1'b0));
    bx0 = xfer0; bx1 = xfer1; bd0 = drop0; bd1 = drop1;
    in_req = 10'h008;
    ticks(20);
    chk("bp_valid", 32'(v0), 32'd1);
    chk("bp_code", 32'(c0), 32'd3);
    in_req = 10'h108;
    ticks(5);
    chk("bp_code_stable", 32'(c0), 32'd3);
    chk("bp_multi_stable", 32'(m0), 32'd0);
    chk("bp_valid_stable", 32'(v0), 32'd1);
    chk("bp_drop_u0", 32'(drop0 - bd0), 32'd1);
    chk("bp_drop_u1", 32'(drop1 - bd1), 32'd1);
    chk("bp_no_xfer", 32'(xfer0 - bx0), 32'd0);
    out_ready = 1'b1;
    ticks(3);
    chk("bp_one_xfer_u0", 32'(xfer0 - bx0), 32'd1);
    chk("bp_one_xfer_u1", 32'(xfer1 - bx1), 32'd1);
    chk("bp_valid_clear", 32'(v0), 32'd0);
    in_req = '0;
    ticks(4);
    chk("bp_drop_total", 32'(drop0 - bd0), 32'd1);

    // Release before accept
    out_ready = 1'b0;
    q0.push_back(mk(4'd0, 1'b0));
    q1.push_back(mk(4'd0, 1'b0));
    bx0 = xfer0;
    in_req = 10'h001;
    ticks(4);
    in_req = '0;
    ticks(6);
    chk("rel_held_valid", 32'(v0), 32'd1);
    chk("rel_held_code", 32'(c0), 32'd0);
    out_ready = 1'b1;
    ticks(12);
    chk("rel_one_xfer", 32'(xfer0 - bx0), 32'd1);
    chk("rel_idle_valid", 32'(v0), 32'd0);

    // Reset mid-HOLD; the first capture is flushed and only the post-reset one transfers
    out_ready = 1'b0;
    bd0 = drop0;
    in_req = 10'h080;
    ticks(5);
    chk("rh_valid", 32'(v0), 32'd1);
    chk("rh_code", 32'(c0), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh_async_valid", 32'(v0), 32'd0);
    chk("rh_async_code", 32'(c0), 32'd0);
    chk("rh_async_multi", 32'(m0), 32'd0);
    chk("rh_async_drop", 32'(e0), 32'd0);
    ticks(3);
    rst_n = 1'b1;
    q0.push_back(mk(4'd7, 1'b0));
    q1.push_back(mk(4'd7, 1'b0));
    ticks(2);
    chk("rh_relat_before", 32'(v0), 32'd0);
    tick();
    chk("rh_relat_valid", 32'(v0), 32'd1);
    chk("rh_relat_code", 32'(c0), 32'd7);
    chk("rh_no_drop", 32'(drop0 - bd0), 32'd0);
    out_ready = 1'b1;
    tick();
    in_req = '0;
    ticks(4);

    // Idle with ready asserted
    bd0 = drop0; bx0 = xfer0;
    out_ready = 1'b1;
    in_req = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_valid", 32'(v0), 32'd0);
      chk("idle_drop", 32'(e0), 32'd0);
    end
    chk("idle_drop_count", 32'(drop0 - bd0), 32'd0);
    chk("idle_xfer_count", 32'(xfer0 - bx0), 32'd0);

    chk("sb_left_u0", 32'(q0.size()), 32'd0);
    chk("sb_left_u1", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
